// File: rtl/top_mul_pipe_acc.sv
// top_mul_pipe_acc: pipelined signed/unsigned multiplier with optional running accumulator and stall-all handshake
module top_mul_pipe_acc #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 64
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  is_signed,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout
);
    localparam int N  = NUM_STAGE + 0 * ID;
    localparam int PW = din0_WIDTH + din1_WIDTH + 2;

    logic                  advance;
    logic                  fin_v, fin_en, fin_clr;
    logic [dout_WIDTH-1:0] fin_p, acc, acc_nxt;

    function automatic logic [dout_WIDTH-1:0] mul(
        input logic [din0_WIDTH-1:0] a,
        input logic [din1_WIDTH-1:0] b,
        input logic                  s
    );
        logic signed [din0_WIDTH:0] ax;
        logic signed [din1_WIDTH:0] bx;
        logic signed [PW-1:0]       p;
        ax = signed'({s & a[din0_WIDTH-1], a});
        bx = signed'({s & b[din1_WIDTH-1], b});
        p  = PW'(ax) * PW'(bx);
        return dout_WIDTH'(p);
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    if (N == 1) begin : g_single
        assign fin_v   = in_valid;
        assign fin_p   = mul(din0, din1, is_signed);
        assign fin_en  = acc_en;
        assign fin_clr = acc_clr;
    end else begin : g_pipe
        logic                  s1_v, s1_s, s1_en, s1_clr;
        logic [din0_WIDTH-1:0] s1_a;
        logic [din1_WIDTH-1:0] s1_b;
        logic [dout_WIDTH-1:0] s1_p;
        // first stage captures the raw beat; the multiply sits after it
        always_ff @(posedge ap_clk)
            if (ap_rst)
                s1_v <= 1'b0;
            else if (advance) begin
                s1_v   <= in_valid;
                s1_a   <= din0;
                s1_b   <= din1;
                s1_s   <= is_signed;
                s1_en  <= acc_en;
                s1_clr <= acc_clr;
            end
        assign s1_p = mul(s1_a, s1_b, s1_s);
        if (N == 2) begin : g_direct
            assign fin_v   = s1_v;
            assign fin_p   = s1_p;
            assign fin_en  = s1_en;
            assign fin_clr = s1_clr;
        end else begin : g_delay
            localparam int MD = N - 2;
            logic [MD-1:0]         mv, men, mclr;
            logic [dout_WIDTH-1:0] mp [MD];
            // delay line carrying the product towards the output register
            always_ff @(posedge ap_clk)
                if (ap_rst)
                    mv <= '0;
                else if (advance) begin
                    mv[0]   <= s1_v;
                    mp[0]   <= s1_p;
                    men[0]  <= s1_en;
                    mclr[0] <= s1_clr;
                    for (int i = 1; i < MD; i++) begin
                        mv[i]   <= mv[i-1];
                        mp[i]   <= mp[i-1];
                        men[i]  <= men[i-1];
                        mclr[i] <= mclr[i-1];
                    end
                end
            assign fin_v   = mv[MD-1];
            assign fin_p   = mp[MD-1];
            assign fin_en  = men[MD-1];
            assign fin_clr = mclr[MD-1];
        end
    end

    // next accumulator value; clear restarts the sum from this product
    always_comb
        acc_nxt = fin_clr ? fin_p : acc + fin_p;

    // output register and accumulator update only when a beat enters the last stage
    always_ff @(posedge ap_clk)
        if (ap_rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            acc       <= '0;
        end else if (advance) begin
            out_valid <= fin_v;
            if (fin_v)
                dout <= fin_en ? acc_nxt : fin_p;
            if (fin_v && fin_en)
                acc <= acc_nxt;
        end
endmodule

// File: tb/tb_top_mul_pipe_acc.sv
// tb_top_mul_pipe_acc: scoreboard bench with randomized and directed beats against an arithmetic reference model
module tb_top_mul_pipe_acc;
    localparam int NS = 3;

    typedef struct {
        logic [63:0] v;
        int          cyc;
    } exp_t;

    logic        ap_clk = 0, ap_rst = 1;
    logic        in_valid = 0, is_signed = 0, acc_en = 0, acc_clr = 0, out_ready = 1;
    logic        in_ready, out_valid;
    logic [31:0] din0 = 0, din1 = 0;
    logic [63:0] dout;

    logic        s_valid = 0, s_signed = 0, s_en = 0, s_clr = 0;
    logic        s_in_ready, s_out_valid;
    logic [3:0]  s_a = 0, s_b = 0;
    logic [7:0]  s_dout;

    exp_t        q[$];
    logic [7:0]  sq[$];
    logic [63:0] m_acc = 0, force_exp = 0, prev_dout = 0;
    logic [7:0]  ms_acc = 0;
    bit          use_force = 0, lat_chk = 1, prev_stall = 0, prev_rst = 1;
    int          rdy_mode = 0, pat = 0, cyc = 0, popped = 0;
    int          total = 0, bad = 0;

    top_mul_pipe_acc #(.ID(1), .NUM_STAGE(NS), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(64)) u_dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    top_mul_pipe_acc #(.ID(2), .NUM_STAGE(1), .din0_WIDTH(4), .din1_WIDTH(4), .dout_WIDTH(8)) u_small (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(s_valid), .in_ready(s_in_ready),
        .din0(s_a), .din1(s_b), .is_signed(s_signed), .acc_en(s_en), .acc_clr(s_clr),
        .out_valid(s_out_valid), .out_ready(1'b1), .dout(s_dout)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc++;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic fail(input string n);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none t=%0t", n, $time);
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'({32'b0, a});
        y = s ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(x * y);
    endfunction

    function automatic logic [7:0] prod8(input logic [3:0] a, input logic [3:0] b, input logic s);
        int x, y;
        x = s ? int'($signed(a)) : int'({28'b0, a});
        y = s ? int'($signed(b)) : int'({28'b0, b});
        return 8'(x * y);
    endfunction

    // input-side monitor: every accepted beat pushes its expected result
    always @(negedge ap_clk) begin
        logic [63:0] p;
        logic [7:0]  p8;
        if (!ap_rst && in_valid && in_ready) begin
            p = prod(din0, din1, is_signed);
            if (acc_en) begin
                m_acc = acc_clr ? p : m_acc + p;
                p = m_acc;
            end
            q.push_back('{use_force ? force_exp : p, cyc});
        end
        if (!ap_rst && s_valid && s_in_ready) begin
            p8 = prod8(s_a, s_b, s_signed);
            if (s_en) begin
                ms_acc = s_clr ? p8 : ms_acc + p8;
                p8 = ms_acc;
            end
            sq.push_back(p8);
        end
    end

    // output-side monitor: handshake rule, stall stability, ordered results and latency
    always @(negedge ap_clk) begin
        exp_t e;
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (prev_stall && !prev_rst) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_dout", dout, prev_dout);
        end
        if (!ap_rst && out_valid && out_ready) begin
            if (q.size() == 0) fail("unexpected_out");
            else begin
                e = q.pop_front();
                chk("dout", dout, e.v);
                if (lat_chk) chk("latency", cyc, e.cyc + NS);
                popped++;
            end
        end
        if (!ap_rst && s_out_valid) begin
            if (sq.size() == 0) fail("small_unexpected_out");
            else chk("small_dout", s_dout, sq.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_dout  = dout;
        prev_rst   = ap_rst;
    end

    initial forever begin
        @(posedge ap_clk);
        #1;
        if (rdy_mode == 0) out_ready = 1;
        else if (rdy_mode == 1) begin
            out_ready = (pat == 0);
            pat = (pat + 1) % 3;
        end else out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic en,
                        input logic clr, input bit fe, input logic [63:0] e);
        int   n = 0;
        logic f;
        in_valid = 1; din0 = a; din1 = b; is_signed = s; acc_en = en; acc_clr = clr;
        use_force = fe; force_exp = e;
        do begin
            @(negedge ap_clk);
            f = in_ready;
            @(posedge ap_clk);
            #1;
            n++;
        end while (!f && n < 100);
        if (!f) chk("send_timeout", f, 1);
        in_valid = 0;
        use_force = 0;
    endtask

    task automatic ssend(input logic [3:0] a, input logic [3:0] b, input logic s, input logic en, input logic clr);
        logic f;
        s_valid = 1; s_a = a; s_b = b; s_signed = s; s_en = en; s_clr = clr;
        @(negedge ap_clk);
        f = s_in_ready;
        @(posedge ap_clk);
        #1;
        s_valid = 0;
        chk("small_in_ready", f, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || sq.size() != 0) && n < 300) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk("drain", q.size() + sq.size(), 0);
    endtask

    task automatic do_reset();
        ap_rst = 1;
        @(posedge ap_clk);
        #1;
        ap_rst = 0;
        q.delete();
        sq.delete();
        m_acc = 0;
        ms_acc = 0;
        @(negedge ap_clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_small_dout", s_dout, 0);
    endtask

    function automatic logic [31:0] pick();
        int k = $urandom_range(0, 5);
        return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'h8000_0000 : 32'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        repeat (3) @(posedge ap_clk);
        #1;
        do_reset();
        @(posedge ap_clk);
        #1;

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1, 64'hFFFF_FFFE_0000_0001);
        send(32'hFFFF_FFFF, 32'h2, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        send(32'hFFFF_FFFF, 32'h2, 0, 0, 0, 1, 64'h0000_0001_FFFF_FFFE);
        send(3, 4, 0, 1, 1, 1, 64'd12);
        send(5, 6, 0, 1, 0, 1, 64'd42);
        send(2, 2, 0, 0, 0, 1, 64'd4);
        send(1, 7, 0, 1, 0, 1, 64'd49);
        drain();

        rdy_mode = 1;
        lat_chk = 0;
        idle(1);
        p0 = popped;
        for (int i = 0; i < 10; i++)
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 0, 0, 0);
        drain();
        chk("bp_count", popped - p0, 10);

        for (int m = 0; m < 3; m++) begin
            rdy_mode = m;
            lat_chk = (m == 0);
            idle(1);
            repeat (80) begin
                send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0, 0, 0);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            drain();
        end

        rdy_mode = 0;
        lat_chk = 1;
        idle(1);
        send(32'd100, 32'd200, 0, 1, 1, 0, 0);
        send(32'd7, 32'd9, 0, 1, 0, 0, 0);
        do_reset();
        repeat (3) begin
            @(negedge ap_clk);
            chk("rst_quiet", out_valid, 0);
        end
        @(posedge ap_clk);
        #1;
        send(2, 3, 0, 1, 0, 1, 64'd6);
        drain();

        ssend(4'hF, 4'hF, 0, 1, 1);
        ssend(4'hF, 4'hF, 0, 1, 0);
        ssend(4'hF, 4'hF, 1, 0, 0);
        ssend(4'h8, 4'h7, 1, 0, 0);
        repeat (20)
            ssend(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
